header_store: RTL
=================

# header_store

Bus responder that holds the 80-byte Bitcoin block header and serves it as 32-bit big-endian words to the SHA-256d hashing core's `rq`/`addr`/`rdy`/`data` read port. The header is loaded byte-serially from the chip's 8-bit input pins in wire (serialization) order. The block also owns the nonce field, which it can increment in place between hash attempts. It sits between the pin-level loader and `sha256d_wrapper`.

## Interface
- No parameters. Header length is fixed at 80 bytes / 20 words.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `wr_en`  in  1  byte write strobe; writes `wr_data` at the load pointer.
- `wr_data`  in  8  header byte, serialization order (byte 0 first).
- `wr_clr`  in  1  restart load: pointer := 0, `loaded` := 0. Contents are retained.
- `nonce_inc`  in  1  increment the nonce field by 1.
- `loaded`  out  1  all 80 bytes written since the last reset or `wr_clr`.
- `nonce`  out  32  numeric nonce: little-endian value of header bytes 76..79.
- `rq`  in  1  read request from the hashing core.
- `addr`  in  5  requested word index.
- `rdy`  out  1  `data` valid for the word requested on the previous cycle.
- `data`  out  32  header word.

## Operation
- Storage is 20 × 32-bit words, `hdr[0..19]`. Byte i lands in word i/4, bits [31-8*(i%4) -: 8]; byte 0 is the MSB of word 0.
- Load pointer `ptr` is 7 bits, range 0..80.
  - `wr_en` with `ptr < 80`: write the byte, `ptr` += 1.
  - When `ptr` reaches 80, `loaded` := 1 on the same edge as the write of byte 79.
  - `wr_en` with `ptr == 80` is ignored. There is no wrap-around.
- Priority in a single cycle: `wr_clr` > `wr_en` > `nonce_inc`.
  - If `wr_clr` and `wr_en` are both high, the byte is discarded and `ptr` := 0.
- Nonce:
  - `nonce` = {hdr[19][7:0], hdr[19][15:8], hdr[19][23:16], hdr[19][31:24]}. This output is combinational from storage.
  - `nonce_inc` is honoured only when `loaded`=1, `rq`=0, `wr_en`=0 and `wr_clr`=0. Otherwise it is ignored and not queued.
  - On increment, hdr[19] := byteswap(nonce + 1), mod 2^32: 0xFFFFFFFF wraps to 0 and hdr[19] becomes 0x00000000.
- Read port:
  - Each cycle, `rdy` := `rq` & `loaded`.
  - When `rq` & `loaded` and `addr` < 20: `data` := hdr[addr].
  - When `rq` & `loaded` and `addr` >= 20: `data` := 0 (`rdy` still 1, so the requester never hangs).
  - `rq`=1 with `loaded`=0: `rdy` stays 0 and the requester stalls until loading completes.
  - `rq`=0: `rdy` := 0 and `data` holds its last value.
- A write on the same cycle as a read of the same word: the read returns the pre-write contents.

## Timing
- Reset values (applied at the first rising edge with `rst_n`=0): hdr all 0, `ptr`=0, `loaded`=0, `rdy`=0, `data`=0, hence `nonce`=0.
- Reset asserted mid-load or mid-read clears everything on that edge. `rdy` is 0 the following cycle.
- Read latency is 1 cycle. `rq`/`addr` sampled at edge N produce `rdy`/`data` valid after edge N, for sampling at edge N+1.
- With `rq` held high, a new `addr` each cycle returns one word per cycle (full throughput, no bubbles).
- Write latency is 1 cycle: byte visible in hdr and on `data` for a read sampled at the next edge.
- `nonce_inc` takes effect in 1 cycle. `nonce` and hdr[19] update on the same edge.

## Test plan
- Reset, then load bytes i = 0..79 with value i, then read with `rq`=1 and `addr`=0, 19, 20 on consecutive cycles -> `loaded`=1 after byte 79; `rdy`=1 each following cycle; `data` = 0x00010203, 0x4C4D4E4F, 0x00000000; `nonce` = 0x4F4E4D4C.
- On the same loaded header, pulse `nonce_inc` once -> `nonce` = 0x4F4E4D4D, hdr[19] = 0x4D4D4E4F. Pulse `nonce_inc` with `rq`=1 -> no change.
- Load bytes 76..79 = 0xFF, then `nonce_inc` -> `nonce` = 0x00000000, read of addr 19 returns 0x00000000.
- Assert `rq`, `addr`=5 after only 40 bytes are written -> `rdy`=0 throughout; finish loading -> `rdy`=1 the cycle after `loaded` rises, `data` = hdr[5].
- Write an 81st byte -> ignored, word 0 unchanged. Then `wr_clr` together with `wr_en` -> `ptr`=0, `loaded`=0, byte dropped; a subsequent write of 0xAA makes word 0 = 0xAA010203.
- Assert `rst_n`=0 mid-load (`ptr`=37) -> next cycle `loaded`=0, `rdy`=0, `data`=0, `nonce`=0; reads after reloading return the new contents only.

Source files
------------

// File: rtl/header_store.sv
// header_store: holds the 80-byte block header and serves it as big-endian
// 32-bit words to the hashing core. The header is loaded byte-serially in
// wire order, and the nonce field (bytes 76..79) can be incremented in place.
//
// Read handshake: the requester raises rq with addr. One cycle later rdy is
// high and data holds the word, provided the header was fully loaded when
// the request was sampled. While loading is incomplete rdy stays low, so the
// requester simply keeps rq asserted until rdy appears. Addresses 20..31
// return zero with rdy high, so the requester never waits forever.
module header_store (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_clr,
    input  logic        nonce_inc,
    output logic        loaded,
    output logic [31:0] nonce,
    input  logic        rq,
    input  logic [4:0]  addr,
    output logic        rdy,
    output logic [31:0] data
);

    localparam int unsigned NUM_WORDS = 20;
    localparam logic [6:0]  LAST_BYTE = 7'd79;
    localparam logic [6:0]  HDR_BYTES = 7'd80;

    logic [31:0] hdr_q [NUM_WORDS];
    logic [31:0] hdr_d [NUM_WORDS];
    logic [6:0]  ptr_q, ptr_d;
    logic        loaded_q, loaded_d;
    logic        rdy_q, rdy_d;
    logic [31:0] data_q, data_d;

    logic [4:0]  wr_word;
    logic [1:0]  wr_lane;
    logic [31:0] nonce_nxt;
    logic        inc_ok;

    // Nonce is the little-endian reading of the last header word.
    assign nonce = {hdr_q[19][7:0], hdr_q[19][15:8], hdr_q[19][23:16], hdr_q[19][31:24]};

    assign loaded = loaded_q;
    assign rdy    = rdy_q;
    assign data   = data_q;

    assign wr_word   = ptr_q[6:2];
    assign wr_lane   = ptr_q[1:0];
    assign nonce_nxt = nonce + 32'd1;
    // Increment only on a quiet cycle of a loaded header; otherwise dropped.
    assign inc_ok    = nonce_inc && loaded_q && !rq && !wr_en && !wr_clr;

    // Storage and load pointer: clear beats byte write beats nonce increment.
    always_comb begin
        hdr_d    = hdr_q;
        ptr_d    = ptr_q;
        loaded_d = loaded_q;
        if (wr_clr) begin
            ptr_d    = 7'd0;
            loaded_d = 1'b0;
        end else if (wr_en) begin
            // A full header ignores further bytes; there is no wrap-around.
            if (ptr_q < HDR_BYTES) begin
                case (wr_lane)
                    2'd0:    hdr_d[wr_word][31:24] = wr_data;
                    2'd1:    hdr_d[wr_word][23:16] = wr_data;
                    2'd2:    hdr_d[wr_word][15:8]  = wr_data;
                    default: hdr_d[wr_word][7:0]   = wr_data;
                endcase
                ptr_d    = ptr_q + 7'd1;
                loaded_d = (ptr_q == LAST_BYTE);
            end
        end else if (inc_ok) begin
            hdr_d[19] = {nonce_nxt[7:0], nonce_nxt[15:8], nonce_nxt[23:16], nonce_nxt[31:24]};
        end
    end

    // Read port: one-cycle latency from pre-write storage; data holds when idle.
    always_comb begin
        rdy_d  = rq && loaded_q;
        data_d = data_q;
        if (rq && loaded_q) begin
            if (addr < 5'(NUM_WORDS)) begin
                data_d = hdr_q[addr];
            end else begin
                data_d = 32'h0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_q    <= '{default: 32'h0};
            ptr_q    <= 7'd0;
            loaded_q <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            hdr_q    <= hdr_d;
            ptr_q    <= ptr_d;
            loaded_q <= loaded_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
        end
    end

endmodule
